// File: rtl/rs_scheduler_pkg.sv
// Shared constants and types for the reservation-station scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rs_scheduler_pkg;

    localparam int NUM_RS    = 4;
    localparam int ROB_IDX_W = 4;
    localparam int RS_IDX_W  = 2;

    // rs_dest encoding meaning "no station chosen"
    localparam logic [2:0] RS_NONE = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } sched_state_t;

    function automatic logic [NUM_RS-1:0] rs_onehot(input logic [RS_IDX_W-1:0] idx);
        logic [NUM_RS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-first selector over eligible reservation stations, age relative to ROB head.
// Latency: purely combinational.
// Backpressure: none; caller decides when to sample the winner.
// Ports: elig (per-RS eligible), rs_rob_flat (ROB entry per RS), rob_head,
//        win_idx/win_rob (chosen RS and its ROB entry), any_vld (some RS eligible).
import rs_scheduler_pkg::*;

module rs_age_picker (
    input  logic [NUM_RS-1:0]           elig,
    input  logic [NUM_RS*ROB_IDX_W-1:0] rs_rob_flat,
    input  logic [ROB_IDX_W-1:0]        rob_head,
    output logic [RS_IDX_W-1:0]         win_idx,
    output logic [ROB_IDX_W-1:0]        win_rob,
    output logic                        any_vld
);

    logic [ROB_IDX_W-1:0] age;
    logic [ROB_IDX_W-1:0] best_age;

    // Ascending scan with strict less-than keeps the lower index on ties.
    // The subtraction wraps modulo 2^ROB_IDX_W, so ages stay correct across
    // ROB index wraparound.
    always_comb begin
        win_idx  = '0;
        win_rob  = '0;
        best_age = '0;
        any_vld  = 1'b0;
        age      = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            age = rs_rob_flat[i*ROB_IDX_W +: ROB_IDX_W] - rob_head;
            if (elig[i] && (!any_vld || (age < best_age))) begin
                any_vld  = 1'b1;
                best_age = age;
                win_idx  = RS_IDX_W'(i);
                win_rob  = rs_rob_flat[i*ROB_IDX_W +: ROB_IDX_W];
            end
        end
    end

endmodule

// File: rtl/rs_scheduler.sv
// RS allocation (combinational lowest-free pick) and oldest-ready dispatch to one FU.
// Latency: ready_bus -> fu_valid 1 cycle; back-to-back dispatch 1 per cycle.
// Backpressure: offer held stable while fu_valid & !fu_ready; alloc stalls when no RS free.
// Ports: clk/reset (sync, active-high), mispredicted (flush), alloc_req -> rs_dest/alloc_stall,
//        busy_bus/ready_bus/rs_rob_flat/rob_head (RS status), fu_valid/fu_sel/fu_rob_entry/
//        fu_ready (dispatch handshake), consumed_bus (one-hot clear to accepted RS).
import rs_scheduler_pkg::*;

module rs_scheduler (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mispredicted,
    input  logic                        alloc_req,
    input  logic [NUM_RS-1:0]           busy_bus,
    input  logic [NUM_RS-1:0]           ready_bus,
    input  logic [NUM_RS*ROB_IDX_W-1:0] rs_rob_flat,
    input  logic [ROB_IDX_W-1:0]        rob_head,
    output logic [2:0]                  rs_dest,
    output logic                        alloc_stall,
    output logic                        fu_valid,
    output logic [RS_IDX_W-1:0]         fu_sel,
    output logic [ROB_IDX_W-1:0]        fu_rob_entry,
    input  logic                        fu_ready,
    output logic [NUM_RS-1:0]           consumed_bus
);

    sched_state_t          state_q, state_d;
    logic                  fu_valid_q, fu_valid_d;
    logic [RS_IDX_W-1:0]   fu_sel_q, fu_sel_d;
    logic [ROB_IDX_W-1:0]  fu_rob_entry_q, fu_rob_entry_d;

    logic [NUM_RS-1:0]     free;
    logic [NUM_RS-1:0]     elig;
    logic [RS_IDX_W-1:0]   low_free_idx;
    logic                  flush;
    logic                  win_any;
    logic [RS_IDX_W-1:0]   win_idx;
    logic [ROB_IDX_W-1:0]  win_rob;

    assign flush = reset | mispredicted;

    // Clear pulse only on a real handshake; a flush in the same cycle drops the offer.
    always_comb begin
        consumed_bus = '0;
        if (fu_valid_q && fu_ready && !flush) begin
            consumed_bus = rs_onehot(fu_sel_q);
        end
    end

    // An RS being consumed this cycle still shows busy; keep it away from
    // allocation until it has actually cleared.
    assign free = ~busy_bus & ~consumed_bus;

    always_comb begin
        low_free_idx = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (free[i]) begin
                low_free_idx = RS_IDX_W'(i);
            end
        end
    end

    always_comb begin
        rs_dest     = RS_NONE;
        alloc_stall = 1'b0;
        if (alloc_req && !flush) begin
            if (|free) begin
                rs_dest = {1'b0, low_free_idx};
            end else begin
                alloc_stall = 1'b1;
            end
        end
    end

    // The RS currently on offer is excluded so the picker already names the
    // follow-on winner for a back-to-back load at the accepting edge.
    always_comb begin
        elig = busy_bus & ready_bus;
        if (fu_valid_q) begin
            elig[fu_sel_q] = 1'b0;
        end
    end

    rs_age_picker u_picker (
        .elig        (elig),
        .rs_rob_flat (rs_rob_flat),
        .rob_head    (rob_head),
        .win_idx     (win_idx),
        .win_rob     (win_rob),
        .any_vld     (win_any)
    );

    always_comb begin
        state_d        = state_q;
        fu_valid_d     = fu_valid_q;
        fu_sel_d       = fu_sel_q;
        fu_rob_entry_d = fu_rob_entry_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_any) begin
                    state_d        = S_OFFER;
                    fu_valid_d     = 1'b1;
                    fu_sel_d       = win_idx;
                    fu_rob_entry_d = win_rob;
                end
            end
            S_OFFER: begin
                // No preemption: the offer only moves on acceptance.
                if (fu_ready) begin
                    if (win_any) begin
                        fu_sel_d       = win_idx;
                        fu_rob_entry_d = win_rob;
                    end else begin
                        state_d    = S_IDLE;
                        fu_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                fu_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q        <= S_IDLE;
            fu_valid_q     <= 1'b0;
            fu_sel_q       <= '0;
            fu_rob_entry_q <= '0;
        end else begin
            state_q        <= state_d;
            fu_valid_q     <= fu_valid_d;
            fu_sel_q       <= fu_sel_d;
            fu_rob_entry_q <= fu_rob_entry_d;
        end
    end

    assign fu_valid     = fu_valid_q;
    assign fu_sel       = fu_sel_q;
    assign fu_rob_entry = fu_rob_entry_q;

endmodule

// File: tb/tb_rs_scheduler.sv
module tb_rs_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        mispredicted;
    logic        alloc_req;
    logic [3:0]  busy_bus;
    logic [3:0]  ready_bus;
    logic [15:0] rs_rob_flat;
    logic [3:0]  rob_head;
    logic [2:0]  rs_dest;
    logic        alloc_stall;
    logic        fu_valid;
    logic [1:0]  fu_sel;
    logic [3:0]  fu_rob_entry;
    logic        fu_ready;
    logic [3:0]  consumed_bus;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rs_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .mispredicted (mispredicted),
        .alloc_req    (alloc_req),
        .busy_bus     (busy_bus),
        .ready_bus    (ready_bus),
        .rs_rob_flat  (rs_rob_flat),
        .rob_head     (rob_head),
        .rs_dest      (rs_dest),
        .alloc_stall  (alloc_stall),
        .fu_valid     (fu_valid),
        .fu_sel       (fu_sel),
        .fu_rob_entry (fu_rob_entry),
        .fu_ready     (fu_ready),
        .consumed_bus (consumed_bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        mispredicted = 1'b0;
        alloc_req    = 1'b1;
        busy_bus     = 4'b0000;
        ready_bus    = 4'b0000;
        rs_rob_flat  = 16'h0000;
        rob_head     = 4'd0;
        fu_ready     = 1'b0;
        tick();
        tick();

        // Held in reset
        chk("rst_rs_dest", 16'(rs_dest), 16'h7);
        chk("rst_stall", 16'(alloc_stall), 16'h0);
        chk("rst_fu_valid", 16'(fu_valid), 16'h0);
        chk("rst_fu_sel", 16'(fu_sel), 16'h0);
        chk("rst_fu_rob", 16'(fu_rob_entry), 16'h0);
        chk("rst_consumed", 16'(consumed_bus), 16'h0);

        // 1. out of reset, nothing busy
        reset = 1'b0;
        settle();
        chk("t1_rs_dest", 16'(rs_dest), 16'h0);
        chk("t1_stall", 16'(alloc_stall), 16'h0);
        chk("t1_fu_valid", 16'(fu_valid), 16'h0);
        chk("t1_consumed", 16'(consumed_bus), 16'h0);

        // 2. full -> stall; then RS1 frees
        busy_bus = 4'b1111;
        settle();
        chk("t2_full_dest", 16'(rs_dest), 16'h7);
        chk("t2_full_stall", 16'(alloc_stall), 16'h1);
        busy_bus = 4'b1101;
        settle();
        chk("t2_rs1_dest", 16'(rs_dest), 16'h1);
        chk("t2_rs1_stall", 16'(alloc_stall), 16'h0);
        alloc_req = 1'b0;
        settle();
        chk("t2_noreq_dest", 16'(rs_dest), 16'h7);
        tick();

        // 3. wrap-safe age: head=14, RS0 rob=2 (age 4), RS2 rob=15 (age 1)
        busy_bus    = 4'b0101;
        ready_bus   = 4'b0101;
        rs_rob_flat = 16'h0F02;
        rob_head    = 4'd14;
        tick();
        chk("t3_valid", 16'(fu_valid), 16'h1);
        chk("t3_sel_rs2", 16'(fu_sel), 16'h2);
        chk("t3_rob_rs2", 16'(fu_rob_entry), 16'hF);
        chk("t3_noacc_consumed", 16'(consumed_bus), 16'h0);
        // accept RS2 while allocating: RS2 being consumed must not be handed out
        fu_ready  = 1'b1;
        alloc_req = 1'b1;
        busy_bus  = 4'b0111;
        settle();
        chk("t3_consumed_rs2", 16'(consumed_bus), 16'h4);
        chk("t3_alloc_skip_consumed", 16'(rs_dest), 16'h3);
        tick();
        chk("t3_b2b_valid", 16'(fu_valid), 16'h1);
        chk("t3_sel_rs0", 16'(fu_sel), 16'h0);
        chk("t3_rob_rs0", 16'(fu_rob_entry), 16'h2);
        busy_bus  = 4'b0011;
        ready_bus = 4'b0001;
        alloc_req = 1'b0;
        settle();
        chk("t3_consumed_rs0", 16'(consumed_bus), 16'h1);
        tick();
        chk("t3_idle_valid", 16'(fu_valid), 16'h0);
        busy_bus  = 4'b0000;
        ready_bus = 4'b0000;
        fu_ready  = 1'b0;
        tick();

        // 4. no preemption: RS1 (age 2) offered, RS0 (age 1) becomes ready
        rob_head    = 4'd3;
        rs_rob_flat = 16'h0054;
        busy_bus    = 4'b0011;
        ready_bus   = 4'b0010;
        tick();
        chk("t4_sel_rs1", 16'(fu_sel), 16'h1);
        ready_bus = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_hold_valid", 16'(fu_valid), 16'h1);
            chk("t4_hold_sel", 16'(fu_sel), 16'h1);
            chk("t4_hold_rob", 16'(fu_rob_entry), 16'h5);
            chk("t4_hold_consumed", 16'(consumed_bus), 16'h0);
        end
        fu_ready = 1'b1;
        settle();
        chk("t4_consumed_rs1", 16'(consumed_bus), 16'h2);
        tick();
        chk("t4_sel_rs0", 16'(fu_sel), 16'h0);
        chk("t4_rob_rs0", 16'(fu_rob_entry), 16'h4);

        // 5. accept RS0, RS3 follows; then flush mid-offer
        busy_bus    = 4'b1001;
        ready_bus   = 4'b1001;
        rs_rob_flat = 16'h7004;
        settle();
        chk("t5_consumed_rs0", 16'(consumed_bus), 16'h1);
        tick();
        chk("t5_sel_rs3", 16'(fu_sel), 16'h3);
        chk("t5_valid_rs3", 16'(fu_valid), 16'h1);
        busy_bus     = 4'b1000;
        ready_bus    = 4'b1000;
        mispredicted = 1'b1;
        alloc_req    = 1'b1;
        settle();
        chk("t5_flush_consumed", 16'(consumed_bus), 16'h0);
        chk("t5_flush_dest", 16'(rs_dest), 16'h7);
        chk("t5_flush_stall", 16'(alloc_stall), 16'h0);
        tick();
        chk("t5_flush_valid", 16'(fu_valid), 16'h0);
        chk("t5_flush_sel", 16'(fu_sel), 16'h0);
        chk("t5_flush_rob", 16'(fu_rob_entry), 16'h0);
        chk("t5_flush_dest2", 16'(rs_dest), 16'h7);
        busy_bus = 4'b1111;
        settle();
        chk("t5_flush_full_stall", 16'(alloc_stall), 16'h0);
        mispredicted = 1'b0;
        alloc_req    = 1'b0;
        busy_bus     = 4'b0000;
        ready_bus    = 4'b0000;
        fu_ready     = 1'b0;
        tick();
        chk("t5_after_valid", 16'(fu_valid), 16'h0);

        // 6. equal age tie -> lower index first
        rs_rob_flat = 16'h0099;
        busy_bus    = 4'b0011;
        ready_bus   = 4'b0011;
        tick();
        chk("t6_sel_rs0", 16'(fu_sel), 16'h0);
        chk("t6_rob_rs0", 16'(fu_rob_entry), 16'h9);
        fu_ready = 1'b1;
        settle();
        chk("t6_consumed_rs0", 16'(consumed_bus), 16'h1);
        tick();
        chk("t6_sel_rs1", 16'(fu_sel), 16'h1);
        busy_bus  = 4'b0010;
        ready_bus = 4'b0010;
        settle();
        chk("t6_consumed_rs1", 16'(consumed_bus), 16'h2);
        tick();
        chk("t6_idle_valid", 16'(fu_valid), 16'h0);

        // reset mid-offer behaves like a flush
        busy_bus    = 4'b0100;
        ready_bus   = 4'b0100;
        rs_rob_flat = 16'h0100;
        fu_ready    = 1'b0;
        tick();
        chk("rst_mid_sel", 16'(fu_sel), 16'h2);
        reset    = 1'b1;
        fu_ready = 1'b1;
        settle();
        chk("rst_mid_consumed", 16'(consumed_bus), 16'h0);
        tick();
        chk("rst_mid_valid", 16'(fu_valid), 16'h0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
